// File: rtl/soc_top.sv
// soc_top: hardwired bus-master controller with a 4-bit parallel port
// and an 8N1 UART sharing one 16-bit I/O bus.

module soc_uart #(
    parameter int BIT_CYCLES = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    input  logic       i_rx_ack,
    output logic       o_irq_req,
    output logic       _rx_pending,
    output logic [7:0] _rx_data,
    output logic       _tx_busy
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t       rx_st;
    logic [2:0]      rx_sync;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;

    logic [9:0]      tx_shift;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;

    assign o_irq_req = _rx_pending;
    assign o_tx      = tx_shift[0];

    // rx_sync[1:0] is the synchronizer, rx_sync[2] the previous sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_st       <= RX_IDLE;
            rx_sync     <= 3'b111;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            _rx_data    <= '0;
            _rx_pending <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[1:0], i_rx};
            if (i_rx_ack)
                _rx_pending <= 1'b0;
            unique case (rx_st)
                RX_IDLE: begin
                    if (rx_sync[2] && !rx_sync[1]) begin
                        rx_st  <= RX_START;
                        rx_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_st <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt <= '0;
                        rx_st  <= RX_IDLE;
                        if (rx_sync[1]) begin
                            _rx_data    <= rx_shift;
                            _rx_pending <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            _tx_busy <= 1'b0;
        end else if (!_tx_busy) begin
            if (i_tx_start) begin
                tx_shift <= {1'b1, i_tx_data, 1'b0};
                tx_cnt   <= '0;
                tx_bit   <= '0;
                _tx_busy <= 1'b1;
            end
        end else if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9)
                _tx_busy <= 1'b0;
            else
                tx_bit <= tx_bit + 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end
endmodule

module soc_periph #(
    parameter int BIT_CYCLES = 868
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    output logic [15:0] o_rdata,
    input  logic [3:0]  i_par_i,
    output logic [3:0]  o_par_o,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_irq_req
);
    logic       hit_par;
    logic       hit_dat;
    logic       hit_sts;
    logic       rx_pending;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       unused_wdata;

    assign hit_par = i_sel && (i_addr == 16'h8200);
    assign hit_dat = i_sel && (i_addr == 16'h8300);
    assign hit_sts = i_sel && (i_addr == 16'h8301);
    assign unused_wdata = ^i_wdata[15:8];

    soc_uart #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_uart_rx),
        .o_tx       (o_uart_tx),
        .i_tx_start (hit_dat && i_we),
        .i_tx_data  (i_wdata[7:0]),
        .i_rx_ack   (hit_dat && i_re),
        .o_irq_req  (o_irq_req),
        ._rx_pending(rx_pending),
        ._rx_data   (rx_data),
        ._tx_busy   (tx_busy)
    );

    always_comb begin
        o_rdata = '0;
        unique case (1'b1)
            hit_par: o_rdata = {12'b0, i_par_i};
            hit_dat: o_rdata = {8'b0, rx_data};
            hit_sts: o_rdata = {14'b0, rx_pending, tx_busy};
            default: o_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_par_o <= '0;
        else if (hit_par && i_we)
            o_par_o <= i_wdata[3:0];
    end
endmodule

module soc_top #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_par_i,
    output logic [3:0] o_par_o,
    input  logic       i_uart_rx,
    output logic       o_uart_tx
);
    localparam int BIT_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;

    typedef enum logic [2:0] {
        C_IDLE,
        C_STAT,
        C_DATA,
        C_PAR,
        C_POLL,
        C_TX,
        C_RET
    } ctl_state_t;

    ctl_state_t  st;
    logic [15:0] _i_ad;
    logic [15:0] _d_ad;
    logic [15:0] _d_wdata;
    logic [15:0] _irq_vector;
    logic [15:0] saved_ad;
    logic [15:0] rdata;
    logic [7:0]  byte_q;
    logic        _io_sel;
    logic        _io_we;
    logic        _io_re;
    logic        _irq_take;
    logic        _in_irq;
    logic        irq_req;
    logic        unused_bits;

    assign _irq_vector = 16'h0020;
    assign unused_bits = ^{_irq_take, rdata[15:8]};

    soc_periph #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_periph (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_addr   (_d_ad),
        .i_wdata  (_d_wdata),
        .i_sel    (_io_sel),
        .i_we     (_io_we),
        .i_re     (_io_re),
        .o_rdata  (rdata),
        .i_par_i  (i_par_i),
        .o_par_o  (o_par_o),
        .i_uart_rx(i_uart_rx),
        .o_uart_tx(o_uart_tx),
        .o_irq_req(irq_req)
    );

    // Each state's bus access is set up one edge ahead so it is on the bus
    // while the state is current.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st        <= C_IDLE;
            _i_ad     <= '0;
            _d_ad     <= '0;
            _d_wdata  <= '0;
            _io_sel   <= 1'b0;
            _io_we    <= 1'b0;
            _io_re    <= 1'b0;
            _irq_take <= 1'b0;
            _in_irq   <= 1'b0;
            saved_ad  <= '0;
            byte_q    <= '0;
        end else begin
            _irq_take <= 1'b0;
            unique case (st)
                C_IDLE: begin
                    if (irq_req && !_in_irq) begin
                        _irq_take <= 1'b1;
                        _in_irq   <= 1'b1;
                        saved_ad  <= {14'd0, _i_ad[1:0] + 2'd1};
                        _i_ad     <= _irq_vector;
                        _d_ad     <= 16'h8301;
                        _io_sel   <= 1'b1;
                        _io_re    <= 1'b1;
                        st        <= C_STAT;
                    end else begin
                        _i_ad <= {14'd0, _i_ad[1:0] + 2'd1};
                    end
                end
                C_STAT: begin
                    _i_ad <= _i_ad + 16'd1;
                    _d_ad <= 16'h8300;
                    st    <= C_DATA;
                end
                C_DATA: begin
                    byte_q   <= rdata[7:0];
                    _i_ad    <= _i_ad + 16'd1;
                    _d_ad    <= 16'h8200;
                    _d_wdata <= {8'h00, rdata[7:0]};
                    _io_re   <= 1'b0;
                    _io_we   <= 1'b1;
                    st       <= C_PAR;
                end
                C_PAR: begin
                    _i_ad    <= _i_ad + 16'd1;
                    _d_ad    <= 16'h8301;
                    _d_wdata <= '0;
                    _io_we   <= 1'b0;
                    _io_re   <= 1'b1;
                    st       <= C_POLL;
                end
                C_POLL: begin
                    if (!rdata[0]) begin
                        _i_ad    <= _i_ad + 16'd1;
                        _d_ad    <= 16'h8300;
                        _d_wdata <= {8'h00, byte_q};
                        _io_re   <= 1'b0;
                        _io_we   <= 1'b1;
                        st       <= C_TX;
                    end
                end
                C_TX: begin
                    _i_ad    <= _i_ad + 16'd1;
                    _d_ad    <= '0;
                    _d_wdata <= '0;
                    _io_sel  <= 1'b0;
                    _io_we   <= 1'b0;
                    st       <= C_RET;
                end
                C_RET: begin
                    _in_irq <= 1'b0;
                    _i_ad   <= saved_ad;
                    st      <= C_IDLE;
                end
                default: st <= C_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_top.sv
// Directed testbench for soc_top: reset, RX interrupt handler, glitch and
// framing rejection, direct bus access, and reset abort.

module tb_soc_top;
    localparam int BITC = 50;

    logic       clk;
    logic       rst;
    logic [3:0] par_i;
    logic [3:0] par_o;
    logic       uart_rx;
    logic       uart_tx;

    int checks;
    int failures;
    int take_count;
    int irq_cycles;
    logic [15:0] take_vec;
    int tx_count;
    int tx_ferr;
    logic [7:0] tx_byte;

    soc_top #(
        .BAUD_RATE(2000000)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_par_i  (par_i),
        .o_par_o  (par_o),
        .i_uart_rx(uart_rx),
        .o_uart_tx(uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        take_count = 0;
        irq_cycles = 0;
        take_vec   = '0;
        forever begin
            @(negedge clk);
            if (dut._irq_take) begin
                take_count = take_count + 1;
                take_vec   = dut._irq_vector;
            end
            if (dut.u_periph.u_uart.o_irq_req)
                irq_cycles = irq_cycles + 1;
        end
    end

    initial begin
        logic [7:0] b;
        tx_count = 0;
        tx_ferr  = 0;
        tx_byte  = '0;
        forever begin
            @(negedge uart_tx);
            repeat (BITC / 2) @(posedge clk);
            #1;
            if (uart_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(posedge clk);
                    #1;
                    b[i] = uart_tx;
                end
                repeat (BITC) @(posedge clk);
                #1;
                if (uart_tx !== 1'b1)
                    tx_ferr = tx_ferr + 1;
                tx_byte  = b;
                tx_count = tx_count + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BITC);
        end
        uart_rx = stop_bit;
        tick(BITC);
        uart_rx = 1'b1;
        tick(20);
    endtask

    task automatic test_reset;
        logic [15:0] exp;
        rst     = 1'b1;
        uart_rx = 1'b1;
        par_i   = 4'h9;
        tick(5);
        checks++;
        if (par_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_par got=%h want=0", par_o);
        end
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx got=%b want=1", uart_tx);
        end
        checks++;
        if (dut._i_ad !== 16'h0000 || dut._in_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl i_ad=%h in_irq=%b want 0/0",
                     dut._i_ad, dut._in_irq);
        end
        checks++;
        if (dut.u_periph.u_uart._rx_pending !== 1'b0 ||
            dut.u_periph.u_uart._tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_uart pend=%b busy=%b want 0/0",
                     dut.u_periph.u_uart._rx_pending,
                     dut.u_periph.u_uart._tx_busy);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            exp = 16'(k % 4);
            checks++;
            if (dut._i_ad !== exp ||
                {dut._io_sel, dut._io_we, dut._io_re} !== 3'b000) begin
                failures++;
                $display("FAIL idle_fetch i_ad=%h strobes=%b want %h/000",
                         dut._i_ad,
                         {dut._io_sel, dut._io_we, dut._io_re}, exp);
            end
        end
    endtask

    task automatic test_rx_irq;
        int t0;
        int i0;
        int x0;
        int n;
        t0 = take_count;
        i0 = irq_cycles;
        x0 = tx_count;
        send_byte(8'hA5, 1'b1);
        checks++;
        if (irq_cycles - i0 == 0) begin
            failures++;
            $display("FAIL irq_rise irq cycles got=0 want>0");
        end
        checks++;
        if (take_count - t0 != 1 || take_vec !== 16'h0020) begin
            failures++;
            $display("FAIL irq_take count=%0d vec=%h want 1/0020",
                     take_count - t0, take_vec);
        end
        checks++;
        if (dut.u_periph.u_uart._rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL rx_data got=%h want=a5",
                     dut.u_periph.u_uart._rx_data);
        end
        checks++;
        if (par_o !== 4'h5) begin
            failures++;
            $display("FAIL handler_par got=%h want=5", par_o);
        end
        checks++;
        if (dut._in_irq !== 1'b0 ||
            dut.u_periph.u_uart.o_irq_req !== 1'b0) begin
            failures++;
            $display("FAIL handler_ret in_irq=%b irq=%b want 0/0",
                     dut._in_irq, dut.u_periph.u_uart.o_irq_req);
        end
        n = 0;
        while (tx_count == x0 && n < 1000) begin
            tick(1);
            n++;
        end
        checks++;
        if (tx_count - x0 != 1 || tx_byte !== 8'hA5 || tx_ferr != 0) begin
            failures++;
            $display("FAIL echo_tx frames=%0d byte=%h ferr=%0d want 1/a5/0",
                     tx_count - x0, tx_byte, tx_ferr);
        end
    endtask

    task automatic test_glitch;
        int t0;
        int i0;
        t0 = take_count;
        i0 = irq_cycles;
        uart_rx = 1'b0;
        tick(10);
        uart_rx = 1'b1;
        tick(600);
        checks++;
        if (dut.u_periph.u_uart._rx_pending !== 1'b0 ||
            irq_cycles != i0 || take_count != t0) begin
            failures++;
            $display("FAIL glitch pend=%b irq=%0d take=%0d want 0/0/0",
                     dut.u_periph.u_uart._rx_pending,
                     irq_cycles - i0, take_count - t0);
        end
    endtask

    task automatic test_bad_stop;
        int t0;
        int i0;
        t0 = take_count;
        i0 = irq_cycles;
        send_byte(8'h3C, 1'b0);
        tick(100);
        checks++;
        if (dut.u_periph.u_uart._rx_pending !== 1'b0 ||
            irq_cycles != i0 || take_count != t0) begin
            failures++;
            $display("FAIL bad_stop pend=%b irq=%0d take=%0d want 0/0/0",
                     dut.u_periph.u_uart._rx_pending,
                     irq_cycles - i0, take_count - t0);
        end
        checks++;
        if (dut.u_periph.u_uart._rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL bad_stop_data got=%h want=a5",
                     dut.u_periph.u_uart._rx_data);
        end
    endtask

    task automatic test_bus_direct;
        int x0;
        int n;
        force dut._in_irq = 1'b1;
        send_byte(8'hA5, 1'b1);
        checks++;
        if (dut.u_periph.u_uart.o_irq_req !== 1'b1) begin
            failures++;
            $display("FAIL held_irq got=%b want=1",
                     dut.u_periph.u_uart.o_irq_req);
        end
        force dut._d_ad    = 16'h8301;
        force dut._d_wdata = 16'h0000;
        force dut._io_sel  = 1'b1;
        force dut._io_re   = 1'b1;
        force dut._io_we   = 1'b0;
        #1;
        checks++;
        if (dut.u_periph.o_rdata !== 16'h0002) begin
            failures++;
            $display("FAIL rd_status got=%h want=0002",
                     dut.u_periph.o_rdata);
        end
        force dut._d_ad = 16'h8200;
        #1;
        checks++;
        if (dut.u_periph.o_rdata !== 16'h0009) begin
            failures++;
            $display("FAIL rd_par got=%h want=0009", dut.u_periph.o_rdata);
        end
        force dut._d_ad = 16'h8300;
        #1;
        checks++;
        if (dut.u_periph.o_rdata !== 16'h00A5) begin
            failures++;
            $display("FAIL rd_data got=%h want=00a5", dut.u_periph.o_rdata);
        end
        tick(1);
        checks++;
        if (dut.u_periph.u_uart._rx_pending !== 1'b0) begin
            failures++;
            $display("FAIL rd_clear pend=%b want=0",
                     dut.u_periph.u_uart._rx_pending);
        end
        x0 = tx_count;
        force dut._io_re   = 1'b0;
        force dut._io_we   = 1'b1;
        force dut._d_wdata = 16'h005A;
        tick(1);
        force dut._io_we = 1'b0;
        force dut._io_re = 1'b1;
        force dut._d_ad  = 16'h8301;
        #1;
        checks++;
        if (dut.u_periph.o_rdata !== 16'h0001) begin
            failures++;
            $display("FAIL busy_status got=%h want=0001",
                     dut.u_periph.o_rdata);
        end
        force dut._d_ad    = 16'h8300;
        force dut._d_wdata = 16'h00C3;
        force dut._io_re   = 1'b0;
        force dut._io_we   = 1'b1;
        n = 0;
        while (n < 700) begin
            tick(1);
            n++;
            if (n == 1) begin
                force dut._io_we  = 1'b0;
                force dut._io_sel = 1'b0;
            end
            if (dut.u_periph.u_uart._tx_busy !== 1'b1)
                break;
        end
        checks++;
        if (n != 10 * BITC) begin
            failures++;
            $display("FAIL busy_len got=%0d want=%0d", n, 10 * BITC);
        end
        release dut._d_ad;
        release dut._d_wdata;
        release dut._io_sel;
        release dut._io_re;
        release dut._io_we;
        release dut._in_irq;
        tick(600);
        checks++;
        if (tx_count - x0 != 1 || tx_byte !== 8'h5A) begin
            failures++;
            $display("FAIL tx_ignore frames=%0d byte=%h want 1/5a",
                     tx_count - x0, tx_byte);
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (dut._in_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_irq got=%b want=0", dut._in_irq);
        end
    endtask

    task automatic test_reset_abort;
        send_byte(8'h3C, 1'b1);
        tick(50);
        checks++;
        if (dut.u_periph.u_uart._tx_busy !== 1'b1 || par_o !== 4'hC) begin
            failures++;
            $display("FAIL echo_busy busy=%b par=%h want 1/c",
                     dut.u_periph.u_uart._tx_busy, par_o);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (uart_tx !== 1'b1 || dut.u_periph.u_uart._tx_busy !== 1'b0 ||
            par_o !== 4'h0) begin
            failures++;
            $display("FAIL tx_abort tx=%b busy=%b par=%h want 1/0/0",
                     uart_tx, dut.u_periph.u_uart._tx_busy, par_o);
        end
        rst = 1'b0;
        tick(2);
        uart_rx = 1'b0;
        tick(100);
        rst     = 1'b1;
        uart_rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(600);
        checks++;
        if (dut.u_periph.u_uart._rx_pending !== 1'b0) begin
            failures++;
            $display("FAIL rx_abort pend=%b want=0",
                     dut.u_periph.u_uart._rx_pending);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        uart_rx  = 1'b1;
        par_i    = 4'h9;
        test_reset;
        test_rx_irq;
        test_glitch;
        test_bad_stop;
        test_bus_direct;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Small SoC: a hardwired bus-master controller, a 4-bit parallel port and an 8N1 UART, all on one 16-bit I/O bus.
- The controller runs an idle fetch loop. On a UART receive interrupt it runs a fixed handler:
  - reads the byte,
  - drives its low nibble onto the parallel output,
  - echoes the byte on TX,
  - returns to the idle loop.
- Top-level block of the FPGA image.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD_RATE, 115200, UART baud rate. Simulation builds use 2000000.
- BIT_CYCLES, (CLK_FREQ+BAUD_RATE/2)/BAUD_RATE, clocks per UART bit (868, or 50 in simulation); derived.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_par_i  in  4  parallel input port.
- o_par_o  out  4  parallel output register.
- i_uart_rx  in  1  UART receive line, idle high.
- o_uart_tx  out  1  UART transmit line, idle high.

Behaviour:
- Probe hierarchy (fixed, for verification):
  - Top level: _i_ad, _d_ad, _io_sel, _io_we, _io_re, _irq_take, _irq_vector, _in_irq.
  - Peripheral instance u_periph, ports i_addr, i_wdata, i_sel, i_we, i_re, o_rdata.
  - UART instance u_periph.u_uart, with o_irq_req, _rx_pending, _rx_data[7:0], _tx_busy.
- Reset values: o_par_o=0, o_uart_tx=1, _i_ad=0, _in_irq=0, rx_pending=0, tx_busy=0. All bus strobes are 0.
- I/O map (i_sel=1 for 0x8000-0x83FF):
  - 0x8200: read {12'b0,i_par_i}; write o_par_o<=wdata[3:0] on the next edge.
  - 0x8300 read: {8'b0,rx_data}. A read (sel&re) clears rx_pending at the edge.
  - 0x8300 write: starts TX of wdata[7:0] if !tx_busy; ignored while busy.
  - 0x8301 read: {14'b0,rx_pending,tx_busy} (bit1 rx_pending, bit0 tx_busy).
  - Other addresses read 0.
- o_rdata is combinational from address and current state (zero-latency read).
- A write sets tx_busy at that same edge, so a status read on the following cycle returns bit0=1.
- UART RX:
  - i_uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts reception. The start bit is re-checked at BIT_CYCLES/2; if high, return to idle (glitch).
  - Then 8 data bits, LSB first, are sampled every BIT_CYCLES, followed by the stop bit.
  - If stop=1: rx_data<=byte and rx_pending<=1. If stop=0: the byte is discarded.
  - A new byte while pending overwrites rx_data; pending stays 1.
  - o_irq_req = rx_pending.
- UART TX:
  - Frame: start (0), 8 data bits LSB first, stop (1), each BIT_CYCLES long.
  - tx_busy clears after the stop bit completes.
- Controller:
  - Idle: _i_ad increments 0x0000..0x0003 and wraps.
  - Interrupt entry: when o_irq_req && !_in_irq at an edge:
    - _irq_take pulses 1 cycle;
    - _irq_vector=0x0020 (constant);
    - _in_irq<=1;
    - _i_ad<=0x0020, incrementing by 1 per handler step.
  - Handler steps, one bus access per cycle, with _d_ad/_io_sel/_io_re/_io_we driven:
    - (1) read 0x8301;
    - (2) read 0x8300, latching the byte internally (clears pending/irq);
    - (3) write 0x8200 with the byte;
    - (4) poll 0x8301 until bit0=0;
    - (5) write 0x8300 with the byte;
    - (6) return: _in_irq<=0, _i_ad<=saved idle address.
  - Bus strobes are 0 when idle.
  - Interrupts are not nested; a byte that arrives during the handler is serviced after return.
- Reset mid-frame aborts RX/TX immediately: TX line high, RX FSM idle.

Test Plan:
- Reset 5 cycles, release -> o_par_o=0, o_uart_tx=1, _i_ad cycles 0..3, no strobes.
- With BAUD_RATE=2000000, send 0xA5 on i_uart_rx. Expected:
  - o_irq_req rises after the stop bit, _rx_data=0xA5;
  - _irq_take pulses once with vector 0x0020;
  - o_par_o becomes 0x5;
  - o_uart_tx emits 0xA5 (50-cycle bits);
  - _in_irq returns to 0.
- Hold controller aside by forcing u_periph bus, after receiving 0xA5:
  - read 0x8301 -> bit1=1;
  - read 0x8300 -> 0x00A5 and pending clears;
  - write 0x8300=0x5A, then read 0x8301 next cycle -> bit0=1;
  - tx_busy drops after 10 bit times.
- Start-bit glitch (rx low for 10 cycles) -> no byte, no IRQ.
- Bad stop bit (0x3C with stop=0) -> no pending, no IRQ.
- Second write to 0x8300 while tx_busy -> ignored; only the first byte is transmitted.
